// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: data width, funct3 width codes
// and FSM state encoding.
package riscv_lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_if.sv
// Data-bus bundle between the LSU (master) and memory (slave).
interface riscv_lsu_if;
    import riscv_lsu_pkg::*;

    logic            dbus_req;
    logic            dbus_we;
    logic [XLEN-1:0] dbus_addr;
    logic [3:0]      dbus_be;
    logic [XLEN-1:0] dbus_wdata;
    logic            dbus_ack;
    logic [XLEN-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_ack, dbus_rdata
    );

endinterface

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: request-side byte enables, store data replication and
// legality check, plus load-side lane extraction with sign/zero extension.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic            req_load_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [1:0]      req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic [3:0]      req_be_o,
    output logic [XLEN-1:0] req_wdata_o,
    output logic            req_misaligned_o,

    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_addr_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_rdata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        req_be_o         = '0;
        req_wdata_o      = req_wdata_i;
        req_misaligned_o = 1'b0;
        if (req_load_i) begin
            req_be_o = '1;
            case (req_funct3_i)
                F3_B, F3_BU: req_misaligned_o = 1'b0;
                F3_H, F3_HU: req_misaligned_o = req_addr_i[0];
                F3_W:        req_misaligned_o = |req_addr_i;
                default:     req_misaligned_o = 1'b1;
            endcase
        end else begin
            case (req_funct3_i)
                F3_B: begin
                    req_be_o    = 4'b0001 << req_addr_i;
                    req_wdata_o = {4{req_wdata_i[7:0]}};
                end
                F3_H: begin
                    req_be_o         = req_addr_i[1] ? 4'b1100 : 4'b0011;
                    req_wdata_o      = {2{req_wdata_i[15:0]}};
                    req_misaligned_o = req_addr_i[0];
                end
                F3_W: begin
                    req_be_o         = 4'b1111;
                    req_misaligned_o = |req_addr_i;
                end
                default: req_misaligned_o = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (ld_addr_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        ld_half = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        case (ld_funct3_i)
            F3_B:    ld_rdata_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_rdata_o = {24'd0, ld_byte};
            F3_H:    ld_rdata_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_rdata_o = {16'd0, ld_half};
            default: ld_rdata_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: holds the pipeline while a single data-bus transfer runs,
// with bus timeout and alignment exceptions.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned DBUS_TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mem_valid,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [2:0]      i_mem_funct3,
    input  logic [XLEN-1:0] i_mem_addr,
    input  logic [XLEN-1:0] i_mem_wdata,
    output logic            o_dbus_req,
    output logic            o_dbus_we,
    output logic [XLEN-1:0] o_dbus_addr,
    output logic [3:0]      o_dbus_be,
    output logic [XLEN-1:0] o_dbus_wdata,
    input  logic            i_dbus_ack,
    input  logic [XLEN-1:0] i_dbus_rdata,
    output logic            o_lsu_stall,
    output logic [XLEN-1:0] o_lsu_rdata,
    output logic            o_lsu_rdata_valid,
    output logic            o_lsu_misaligned,
    output logic            o_lsu_bus_err
);

    lsu_state_e      state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            access;
    logic [3:0]      req_be;
    logic [XLEN-1:0] req_wdata;
    logic            req_mis;
    logic [XLEN-1:0] ld_rdata;

    // Inputs are gated by reset so stall/misaligned stay low while reset is held.
    assign access = i_mem_valid & (i_mem_read | i_mem_write) & ~i_rst;

    riscv_lsu_align u_align (
        .req_load_i       (i_mem_read),
        .req_funct3_i     (i_mem_funct3),
        .req_addr_i       (i_mem_addr[1:0]),
        .req_wdata_i      (i_mem_wdata),
        .req_be_o         (req_be),
        .req_wdata_o      (req_wdata),
        .req_misaligned_o (req_mis),
        .ld_funct3_i      (f3_q),
        .ld_addr_i        (addr_q[1:0]),
        .ld_rdata_i       (i_dbus_rdata),
        .ld_rdata_o       (ld_rdata)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
        we_d             = we_q;
        f3_d             = f3_q;
        rdata_d          = rdata_q;
        err_d            = err_q;
        o_lsu_stall      = 1'b0;
        o_lsu_misaligned = 1'b0;
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (access) begin
                    if (req_mis) begin
                        o_lsu_misaligned = 1'b1;
                    end else begin
                        o_lsu_stall = 1'b1;
                        state_d     = ST_REQ;
                        cnt_d       = '0;
                        addr_d      = i_mem_addr;
                        wdata_d     = req_wdata;
                        be_d        = req_be;
                        we_d        = ~i_mem_read;
                        f3_d        = i_mem_funct3;
                    end
                end
            end
            ST_REQ: begin
                o_lsu_stall = 1'b1;
                if (i_dbus_ack) begin
                    state_d = ST_DONE;
                    if (!we_q) rdata_d = ld_rdata;
                end else if (cnt_q == DBUS_TIMEOUT - 1) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign o_dbus_req        = (state_q == ST_REQ);
    assign o_dbus_we         = we_q;
    assign o_dbus_addr       = {addr_q[XLEN-1:2], 2'b00};
    assign o_dbus_be         = be_q;
    assign o_dbus_wdata      = wdata_q;
    assign o_lsu_rdata       = rdata_q;
    assign o_lsu_rdata_valid = (state_q == ST_DONE) & ~we_q;
    assign o_lsu_bus_err     = (state_q == ST_DONE) & err_q;

endmodule
